// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants and receiver state encoding for the UART receive path.
package uart_rx_fifo_pkg;

  localparam int UART_CLKS_9600 = 5207;
  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Single-clock first-word-fall-through byte FIFO with overrun flag.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count,
  output logic             overrun
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  assign empty   = (count == '0);
  assign full    = (count == (AW + 1)'(DEPTH));
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Storage array: data only, not cleared by reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and overrun pulse; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push & ~push_ok;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (LSB first) feeding a byte FIFO with a pop handshake.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_9600,
  parameter int DEPTH        = 16,
  parameter int AW           = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_i,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          frame_err,
  output logic          overrun
);

  localparam int            BW          = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] FULL_RELOAD = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_RELOAD = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    LAST_BIT    = 3'(UART_DATA_BITS - 1);

  logic [1:0]  sync;
  logic        rxs;
  rx_state_t   state;
  logic [BW-1:0] baud;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        push;

  assign rxs = sync[1];

  // The byte is complete and pushed on the very edge the stop bit is seen high.
  assign push = (state == ST_STOP) && (baud == '0) && rxs;

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], rx_i};
  end

  // Receive FSM: half-bit delay centres all later samples in their bit cells.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      baud      <= '0;
      bit_idx   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!rxs) begin
            bit_idx <= '0;
            baud    <= HALF_RELOAD;
            state   <= ST_START;
          end
        end
        ST_START: begin
          if (baud == '0) begin
            if (rxs) begin
              state <= ST_IDLE;
            end else begin
              baud  <= FULL_RELOAD;
              state <= ST_DATA;
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
        ST_DATA: begin
          if (baud == '0) begin
            baud <= FULL_RELOAD;
            if (bit_idx == LAST_BIT) state <= ST_STOP;
            else                     bit_idx <= bit_idx + 1'b1;
          end else begin
            baud <= baud - 1'b1;
          end
        end
        ST_STOP: begin
          if (baud == '0) begin
            if (rxs) begin
              state <= ST_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
        ST_BREAK: begin
          if (rxs) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Data shift register, LSB arrives first so bits enter from the top.
  always_ff @(posedge clk) begin
    if (state == ST_DATA && baud == '0) shreg <= {rxs, shreg[7:1]};
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (shreg),
    .pop     (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .overrun (overrun)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 16 clocks per bit and a 4-entry FIFO.
module tb_uart_rx_fifo;
  import uart_rx_fifo_pkg::*;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_i = 1'b1;
  logic          rd_en = 1'b0;
  logic [7:0]    rd_data;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          frame_err;
  logic          overrun;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int t_start = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_i      (rx_i),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (overrun)   ov_cnt = ov_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stp);
    @(posedge clk);
    #1;
    rx_i = 1'b0;
    t_start = cyc;
    for (int i = 0; i < 8; i++) begin
      idle(CPB);
      rx_i = b[i];
    end
    idle(CPB);
    rx_i = stp;
    idle(CPB);
  endtask

  task automatic pop1;
    rd_en = 1'b1;
    idle(1);
    rd_en = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    @(negedge clk);
    chk(tag, rd_data, exp);
    @(posedge clk);
    #1;
    pop1();
  endtask

  initial begin
    int  lat;
    bit  got;
    bit  seen;

    // Reset values
    idle(3);
    @(negedge clk);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_state", dut.state, ST_IDLE);
    idle(1);
    rst = 1'b0;
    idle(5);

    // 1: single byte, latency and pop
    got = 0;
    lat = 0;
    fork
      send_byte(8'hA5, 1'b1);
      begin
        for (int k = 0; k < 400 && !got; k++) begin
          @(negedge clk);
          if (!empty) begin
            got = 1;
            lat = cyc - t_start;
          end
        end
      end
    join
    chk("t1_arrived", got, 1);
    chk("t1_latency_ok", (lat >= 152 && lat <= 157), 1);
    @(negedge clk);
    chk("t1_rd_data", rd_data, 8'hA5);
    chk("t1_count", count, 1);
    @(posedge clk);
    #1;
    pop1();
    @(negedge clk);
    chk("t1_empty_after_pop", empty, 1);
    chk("t1_rd_data_after_pop", rd_data, 8'h00);

    // 2: short glitch then a real byte
    idle(5);
    rx_i = 1'b0;
    idle(4);
    rx_i = 1'b1;
    idle(20);
    @(negedge clk);
    chk("t2_count", count, 0);
    chk("t2_no_frame_err", fe_cnt, 0);
    chk("t2_state_idle", dut.state, ST_IDLE);
    send_byte(8'h3C, 1'b1);
    idle(2);
    @(negedge clk);
    chk("t2_rd_data", rd_data, 8'h3C);
    chk("t2_count_after", count, 1);
    @(posedge clk);
    #1;
    pop1();

    // 3: framing error, held break, recovery
    idle(5);
    send_byte(8'h55, 1'b0);
    idle(2);
    @(negedge clk);
    chk("t3_frame_err_once", fe_cnt, 1);
    chk("t3_count", count, 0);
    idle(100);
    rx_i = 1'b1;
    idle(20);
    send_byte(8'h0F, 1'b1);
    idle(2);
    @(negedge clk);
    chk("t3_rd_data", rd_data, 8'h0F);
    chk("t3_no_second_fe", fe_cnt, 1);
    @(posedge clk);
    #1;
    pop1();

    // 4: fill past full, overrun on the fifth byte
    idle(5);
    for (int b = 1; b <= 4; b++) begin
      send_byte(8'(b), 1'b1);
      idle(2);
    end
    @(negedge clk);
    chk("t4_full", full, 1);
    chk("t4_count", count, 4);
    chk("t4_no_overrun_yet", ov_cnt, 0);
    send_byte(8'h05, 1'b1);
    idle(2);
    @(negedge clk);
    chk("t4_overrun", ov_cnt, 1);
    chk("t4_count_after", count, 4);
    pop_chk("t4_pop1", 8'h01);
    pop_chk("t4_pop2", 8'h02);
    pop_chk("t4_pop3", 8'h03);
    pop_chk("t4_pop4", 8'h04);
    @(negedge clk);
    chk("t4_empty", empty, 1);

    // 5: push and pop on the same edge while full
    idle(5);
    for (int b = 1; b <= 4; b++) begin
      send_byte(8'(b), 1'b1);
      idle(2);
    end
    seen = 0;
    fork
      send_byte(8'h77, 1'b1);
      begin
        for (int k = 0; k < 400 && !seen; k++) begin
          @(negedge clk);
          if (dut.push) begin
            seen = 1;
            rd_en = 1'b1;
            @(posedge clk);
            #1;
            rd_en = 1'b0;
          end
        end
      end
    join
    idle(2);
    @(negedge clk);
    chk("t5_push_seen", seen, 1);
    chk("t5_no_overrun", ov_cnt, 1);
    chk("t5_count", count, 4);
    pop_chk("t5_pop1", 8'h02);
    pop_chk("t5_pop2", 8'h03);
    pop_chk("t5_pop3", 8'h04);
    pop_chk("t5_pop4", 8'h77);
    @(negedge clk);
    chk("t5_empty", empty, 1);

    // 6: reset mid-frame with bytes queued
    idle(5);
    send_byte(8'hAA, 1'b1);
    idle(2);
    send_byte(8'hBB, 1'b1);
    idle(2);
    @(negedge clk);
    chk("t6_count_before", count, 2);
    fork
      send_byte(8'h99, 1'b1);
      begin
        idle(80);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_rd_data", rd_data, 8'h00);
        chk("t6_rst_empty", empty, 1);
        chk("t6_rst_full", full, 0);
        chk("t6_rst_count", count, 0);
        chk("t6_rst_state", dut.state, ST_IDLE);
      end
    join
    rx_i = 1'b1;
    idle(5);
    rst = 1'b0;
    idle(5);
    send_byte(8'hC3, 1'b1);
    idle(2);
    @(negedge clk);
    chk("t6_rd_data", rd_data, 8'hC3);
    chk("t6_count_after", count, 1);
    chk("t6_fe_unchanged", fe_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
